// File: rtl/report_sequencer.sv
// Front-end sequencer for the report-safety processor: parses an ASCII level stream,
// feeds levels to the processor, and counts safe/unsafe report verdicts.
// Optional cycle counter output perf_cycles enabled by defining REPORT_SEQ_PERF_EN.
module report_sequencer #(
  parameter int CNT_W   = 16,
  parameter int VAL_MAX = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [7:0]       proc_read_val,
  output logic             proc_en,
  output logic             proc_newline,
  output logic             proc_rst_n,
  input  logic             proc_is_safe,
  input  logic             proc_is_unsafe,
  output logic [CNT_W-1:0] safe_count,
  output logic [CNT_W-1:0] unsafe_count,
  output logic             done,
`ifdef REPORT_SEQ_PERF_EN
  output logic [31:0]      perf_cycles,
`endif
  output logic             err
);

  // state    | meaning
  // PARSE    | accepting bytes, building levels
  // ISSUE    | proc_en pulse with the buffered level
  // WAIT_RES | processor verdict valid, update counters
  // CLEAR    | proc_rst_n low, per-report state wiped
  // DONE     | stream finished, done held until rst
  typedef enum logic [2:0] {S_PARSE, S_ISSUE, S_WAIT_RES, S_CLEAR, S_DONE} state_t;

  state_t      state;
  logic [7:0]  acc;
  logic        have_dig;
  logic [7:0]  pend;
  logic        pend_v;
  logic [1:0]  nvals;
  logic        last_seen;
  logic        nl;
  logic        eol_pend;

  logic        take, is_digit, is_nl, is_sep, is_bad, dig_sat, hd_n, eol, term;
  logic [11:0] prod;
  logic [7:0]  acc_n;
  logic [1:0]  nvals_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction

  always_comb begin
    take      = in_valid && in_ready && (state == S_PARSE);
    is_digit  = (in_data >= 8'h30) && (in_data <= 8'h39);
    is_nl     = (in_data == 8'h0A);
    is_sep    = (in_data == 8'h20) || (in_data == 8'h0D);
    is_bad    = !is_digit && !is_nl && !is_sep;
    prod      = 12'(acc) * 12'd10 + 12'(in_data[3:0]);
    dig_sat   = prod > 12'(VAL_MAX);
    acc_n     = acc;
    if (is_digit) acc_n = dig_sat ? 8'(VAL_MAX) : prod[7:0];
    hd_n      = have_dig || is_digit;
    // in_last closes the report implicitly when anything is still open
    eol       = is_nl || (in_last && (hd_n || pend_v));
    term      = !is_digit || eol;
    nvals_inc = (nvals == 2'd2) ? 2'd2 : nvals + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_CLEAR;
      acc           <= '0;
      have_dig      <= 1'b0;
      pend          <= '0;
      pend_v        <= 1'b0;
      nvals         <= '0;
      last_seen     <= 1'b0;
      nl            <= 1'b0;
      eol_pend      <= 1'b0;
      in_ready      <= 1'b0;
      proc_read_val <= '0;
      proc_en       <= 1'b0;
      proc_newline  <= 1'b0;
      proc_rst_n    <= 1'b0;
      safe_count    <= '0;
      unsafe_count  <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      proc_en      <= 1'b0;
      proc_newline <= 1'b0;
      proc_rst_n   <= 1'b1;
      in_ready     <= 1'b0;
      case (state)
        S_PARSE: begin
          in_ready <= 1'b1;
          if (take) begin
            if (in_last) last_seen <= 1'b1;
            if ((is_digit && dig_sat) || is_bad) err <= 1'b1;
            acc      <= acc_n;
            have_dig <= hd_n;
            if (term && hd_n && pend_v) begin
              // older level goes out first; the new one stays in acc until ISSUE
              state         <= S_ISSUE;
              in_ready      <= 1'b0;
              proc_en       <= 1'b1;
              proc_read_val <= pend;
              nl            <= 1'b0;
              eol_pend      <= eol;
            end else begin
              if (term && hd_n) begin
                pend     <= acc_n;
                pend_v   <= 1'b1;
                acc      <= '0;
                have_dig <= 1'b0;
                nvals    <= nvals_inc;
              end
              if (eol && ((term && hd_n) || (pend_v && nvals == 2'd1))) begin
                safe_count <= sat_inc(safe_count);
                state      <= S_CLEAR;
                in_ready   <= 1'b0;
                proc_rst_n <= 1'b0;
              end else if (eol && pend_v) begin
                state         <= S_ISSUE;
                in_ready      <= 1'b0;
                proc_en       <= 1'b1;
                proc_read_val <= pend;
                proc_newline  <= 1'b1;
                nl            <= 1'b1;
              end else if (in_last) begin
                state      <= S_CLEAR;
                in_ready   <= 1'b0;
                proc_rst_n <= 1'b0;
              end
            end
          end
        end
        S_ISSUE: begin
          if (!nl) begin
            pend     <= acc;
            acc      <= '0;
            have_dig <= 1'b0;
            nvals    <= nvals_inc;
            if (eol_pend) begin
              eol_pend      <= 1'b0;
              nl            <= 1'b1;
              proc_en       <= 1'b1;
              proc_read_val <= acc;
              proc_newline  <= 1'b1;
            end else begin
              state    <= S_PARSE;
              in_ready <= 1'b1;
            end
          end else begin
            pend_v <= 1'b0;
            state  <= S_WAIT_RES;
          end
        end
        S_WAIT_RES: begin
          if (proc_is_safe && !proc_is_unsafe) begin
            safe_count <= sat_inc(safe_count);
          end else begin
            unsafe_count <= sat_inc(unsafe_count);
            if (proc_is_safe == proc_is_unsafe) err <= 1'b1;
          end
          state      <= S_CLEAR;
          proc_rst_n <= 1'b0;
        end
        S_CLEAR: begin
          nvals    <= '0;
          acc      <= '0;
          have_dig <= 1'b0;
          pend_v   <= 1'b0;
          eol_pend <= 1'b0;
          if (last_seen) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state    <= S_PARSE;
            in_ready <= 1'b1;
          end
        end
        default: state <= S_DONE;
      endcase
    end
  end

`ifdef REPORT_SEQ_PERF_EN
  logic perf_run;
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_run    <= 1'b0;
      perf_cycles <= '0;
    end else begin
      if (take) perf_run <= 1'b1;
      if ((perf_run || take) && !done) perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_report_sequencer.sv
// Bench for report_sequencer: directed streams, a behavioural report-safety processor
// (with single-level dampening) and a scoreboard of expected processor issues.
module tb_report_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid, in_last, in_ready;
  logic [7:0]  proc_read_val;
  logic        proc_en, proc_newline, proc_rst_n;
  logic        proc_is_safe, proc_is_unsafe;
  logic [15:0] safe_count, unsafe_count;
  logic        done, err;
`ifdef REPORT_SEQ_PERF_EN
  logic [31:0] perf_cycles;
`endif

  report_sequencer #(.CNT_W(16), .VAL_MAX(255)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .proc_read_val(proc_read_val), .proc_en(proc_en),
    .proc_newline(proc_newline), .proc_rst_n(proc_rst_n), .proc_is_safe(proc_is_safe),
    .proc_is_unsafe(proc_is_unsafe), .safe_count(safe_count), .unsafe_count(unsafe_count),
    .done(done),
`ifdef REPORT_SEQ_PERF_EN
    .perf_cycles(perf_cycles),
`endif
    .err(err));

  always #5 clk = ~clk;

  int nchecks = 0;
  int nerrors = 0;
  int en_pulses = 0;
  int clr_pulses = 0;
  logic prev_rstn = 1'b0;

  typedef struct { int v; bit nl; } issue_t;
  issue_t exp_q[$];
  int hist[$];

  function automatic bit seq_ok(input int q[$], input int skip);
    int prev, dir, cnt, d;
    bit ok;
    ok = 1; cnt = 0; dir = 0; prev = 0;
    for (int i = 0; i < q.size(); i++) begin
      if (i != skip) begin
        if (cnt > 0) begin
          d = q[i] - prev;
          if (d == 0 || d > 3 || d < -3) ok = 0;
          if (dir == 0) dir = (d > 0) ? 1 : -1;
          else if ((d > 0) != (dir > 0)) ok = 0;
        end
        prev = q[i];
        cnt++;
      end
    end
    return ok;
  endfunction

  function automatic bit report_safe(input int q[$]);
    for (int s = -1; s < q.size(); s++)
      if (seq_ok(q, s)) return 1;
    return 0;
  endfunction

  // behavioural processor: verdict registered on the newline-tagged level
  always @(posedge clk) begin
    if (!proc_rst_n) begin
      hist.delete();
      proc_is_safe   <= 1'b0;
      proc_is_unsafe <= 1'b0;
    end else if (proc_en) begin
      hist.push_back(int'(proc_read_val));
      if (proc_newline) begin
        proc_is_safe   <= report_safe(hist);
        proc_is_unsafe <= !report_safe(hist);
      end
    end
  end

  always @(negedge clk) begin
    if (proc_en) begin
      en_pulses++;
      nchecks++;
      assert (exp_q.size() != 0) else begin
        nerrors++;
        $error("FAIL issue_unexpected observed val=%0d nl=%0b expected none", proc_read_val, proc_newline);
      end
      if (exp_q.size() != 0) begin
        issue_t e;
        e = exp_q.pop_front();
        nchecks++;
        assert (proc_read_val === 8'(e.v) && proc_newline === e.nl) else begin
          nerrors++;
          $error("FAIL issue_value observed val=%0d nl=%0b expected val=%0d nl=%0b",
                 proc_read_val, proc_newline, e.v, e.nl);
        end
      end
    end
    if (!rst && !proc_rst_n && prev_rstn) clr_pulses++;
    prev_rstn = proc_rst_n;
  end

  task automatic check(input string tag, input int obs, input int expv);
    nchecks++;
    assert (obs === expv) else begin
      nerrors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push(input int v, input bit nl);
    issue_t e;
    e.v = v; e.nl = nl;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last);
    int n;
    n = 0;
    in_data = b; in_valid = 1'b1; in_last = last;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("handshake_timeout", n < 100, 1);
    @(posedge clk); #1;
  endtask

  task automatic send_str(input string s, input bit last_on_end, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i], last_on_end && (i == s.len() - 1));
      if (gap > 0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_last  = 1'($urandom);
        repeat (gap) begin @(posedge clk); #1; end
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(in_ready || done) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_timeout", n < 100, 1);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    int c0;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_safe", safe_count, 0);
    check("rst_unsafe", unsafe_count, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_proc_en", proc_en, 0);
    check("rst_proc_rst_n", proc_rst_n, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_read_val", proc_read_val, 0);

    // single safe report, decreasing
    do_reset();
    en_pulses = 0;
    push(7, 0); push(6, 0); push(4, 0); push(2, 0); push(1, 1);
    send_str("7 6 4 2 1\n", 1, 0);
    wait_idle();
    check("t1_pulses", en_pulses, 5);
    check("t1_safe", safe_count, 1);
    check("t1_unsafe", unsafe_count, 0);
    check("t1_done", done, 1);
    check("t1_err", err, 0);
    check("t1_q_empty", exp_q.size(), 0);

    // unsafe then dampened-safe report, with a clear pulse after each
    do_reset();
    c0 = clr_pulses;
    push(1, 0); push(2, 0); push(7, 0); push(8, 0); push(9, 1);
    send_str("1 2 7 8 9\n", 0, 0);
    wait_idle();
    check("t2_unsafe_first", unsafe_count, 1);
    check("t2_safe_first", safe_count, 0);
    check("t2_clear_between", clr_pulses - c0, 1);
    push(1, 0); push(3, 0); push(2, 0); push(4, 0); push(5, 1);
    send_str("1 3 2 4 5\n", 1, 0);
    wait_idle();
    check("t2_safe", safe_count, 1);
    check("t2_unsafe", unsafe_count, 1);
    check("t2_done", done, 1);
    check("t2_clear_total", clr_pulses - c0, 2);

    // single-level report, empty line, trailing space and CR
    do_reset();
    en_pulses = 0;
    push(3, 0); push(4, 1);
    send_str("5\n\n3 4 \r\n", 1, 0);
    wait_idle();
    check("t3_safe", safe_count, 2);
    check("t3_unsafe", unsafe_count, 0);
    check("t3_pulses", en_pulses, 2);
    check("t3_err", err, 0);
    check("t3_done", done, 1);

    // level saturation and bad byte
    do_reset();
    push(255, 0); push(1, 1);
    send_str("300 1\n", 0, 0);
    wait_idle();
    check("t4_err_sat", err, 1);
    push(12, 0); push(3, 1);
    send_str("12 3a\n", 1, 0);
    wait_idle();
    check("t4_err", err, 1);
    check("t4_safe", safe_count, 2);
    check("t4_unsafe", unsafe_count, 0);
    check("t4_q_empty", exp_q.size(), 0);

    // gapped input with junk while idle, implicit newline on in_last
    do_reset();
    push(1, 0); push(2, 0); push(7, 0); push(8, 0); push(9, 1);
    push(1, 0); push(3, 0); push(2, 0); push(4, 0); push(5, 1);
    send_str("1 2 7 8 9\n1 3 2 4 5", 1, 2);
    wait_idle();
    check("t5_safe", safe_count, 1);
    check("t5_unsafe", unsafe_count, 1);
    check("t5_done", done, 1);
    check("t5_err", err, 0);

    // reset in the middle of a report
    do_reset();
    push(1, 0);
    send_str("1 2 3", 0, 0);
    repeat (3) begin @(posedge clk); #1; end
    check("t6_pre_q_empty", exp_q.size(), 0);
    do_reset();
    check("t6_rst_safe", safe_count, 0);
    push(9, 0); push(7, 0); push(6, 1);
    send_str("9 7 6\n", 1, 0);
    wait_idle();
    check("t6_safe", safe_count, 1);
    check("t6_unsafe", unsafe_count, 0);
    check("t6_done", done, 1);
    check("t6_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
